// File: rtl/line_buffer_3x3.sv
// -----------------------------------------------------------------------------
// line_buffer_3x3
//
// Streaming 3x3 neighbourhood generator. It accepts a raster-order 8-bit pixel
// stream with at most one pixel per cycle. Two line RAMs hold the previous two
// rows. For every interior pixel it emits the full 3x3 window that ends at the
// pixel just accepted. Border centres are never emitted.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       synchronous reset, active HIGH (resets when 1)
//   in_valid    in_pixel is accepted on this edge
//   in_sof      start of frame, qualified by in_valid; marks pixel (0,0)
//   in_pixel    8-bit input pixel
//   out_valid   win / out_x / out_y are valid this cycle
//   win         3x3 window; element (r,c) at bits [8*(3r+c)+7 : 8*(3r+c)],
//               r=0 is the oldest row, c=0 is the leftmost column
//   out_x       column of the window centre
//   out_y       row of the window centre
//   frame_done  one-cycle pulse: last pixel of the frame accepted
//   sync_err    one-cycle pulse: in_sof arrived while the frame was incomplete
// -----------------------------------------------------------------------------
module line_buffer_3x3 #(
   parameter int unsigned IMG_WIDTH  = 640,
   parameter int unsigned IMG_HEIGHT = 480,
   parameter int unsigned XW         = $clog2(IMG_WIDTH),
   parameter int unsigned YW         = $clog2(IMG_HEIGHT)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic          in_sof,
   input  logic [7:0]    in_pixel,
   output logic          out_valid,
   output logic [71:0]   win,
   output logic [XW-1:0] out_x,
   output logic [YW-1:0] out_y,
   output logic          frame_done,
   output logic          sync_err
);

   localparam logic [XW-1:0] XLast = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0] YLast = YW'(IMG_HEIGHT - 1);

   // Position of the next pixel to be accepted.
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;

   // Effective position of the pixel being offered this cycle. A start of
   // frame forces it to (0,0) regardless of where the counters stand.
   logic [XW-1:0] px;
   logic [YW-1:0] py;

   logic          emit;
   logic          frame_end;
   logic          sof_err;
   logic          accept;

   // Line RAMs: l1 holds row y-1, l2 holds row y-2. Not reset; a row is always
   // rewritten by the current frame before any window can read it.
   logic [7:0]    l1_mem [IMG_WIDTH];
   logic [7:0]    l2_mem [IMG_WIDTH];
   logic [7:0]    l1_rd;
   logic [7:0]    l2_rd;

   // Window shift register, same layout as win.
   logic [71:0]   wnd_q, wnd_d;
   logic          clr;

   // -------------------------------------------------------------------------
   // Position decode
   // -------------------------------------------------------------------------
   always_comb begin
      px        = in_sof ? '0 : x_q;
      py        = in_sof ? '0 : y_q;
      accept    = in_valid && !rst_n;
      emit      = (px >= XW'(2)) && (py >= YW'(2));
      frame_end = (px == XLast) && (py == YLast);
      sof_err   = in_sof && ((x_q != '0) || (y_q != '0));
   end

   always_comb begin
      if (px == XLast) begin
         x_d = '0;
         y_d = (py == YLast) ? '0 : py + YW'(1);
      end else begin
         x_d = px + XW'(1);
         y_d = py;
      end
   end

   // -------------------------------------------------------------------------
   // Line RAMs: read and write share the address, so the read sees the value
   // from the previous row before it is overwritten.
   // -------------------------------------------------------------------------
   assign l1_rd = l1_mem[px];
   assign l2_rd = l2_mem[px];

   always_ff @(posedge clk) begin
      if (accept) begin
         l2_mem[px] <= l1_rd;
         l1_mem[px] <= in_pixel;
      end
   end

   // -------------------------------------------------------------------------
   // Window next state. Each 24-bit row shifts one byte towards c=0 and takes
   // the new pixel of that row at c=2. At column 0 the two older columns are
   // cleared so a window never spans a row boundary.
   // -------------------------------------------------------------------------
   assign clr = (px == '0);

   always_comb begin
      wnd_d = {in_pixel, clr ? 16'h0000 : wnd_q[71:56],
               l1_rd,    clr ? 16'h0000 : wnd_q[47:32],
               l2_rd,    clr ? 16'h0000 : wnd_q[23:8]};
   end

   // -------------------------------------------------------------------------
   // State and registered outputs
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst_n) begin
         x_q        <= '0;
         y_q        <= '0;
         wnd_q      <= '0;
         out_valid  <= 1'b0;
         win        <= '0;
         out_x      <= '0;
         out_y      <= '0;
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
      end else begin
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
         if (in_valid) begin
            x_q        <= x_d;
            y_q        <= y_d;
            wnd_q      <= wnd_d;
            frame_done <= frame_end;
            sync_err   <= sof_err;
            if (emit) begin
               out_valid <= 1'b1;
               win       <= wnd_d;
               out_x     <= px - XW'(1);
               out_y     <= py - YW'(1);
            end
         end
      end
   end

endmodule

// File: doc/line_buffer_3x3.md
# line_buffer_3x3

Streaming 3x3 neighbourhood generator for the edge_detection pipeline. It accepts a raster-order 8-bit pixel stream, one pixel per cycle at most, and stores the two previous image rows in line RAMs. For every interior pixel it emits a complete 3x3 window, which feeds the Gaussian and gradient kernels downstream.

## Interface
- IMG_WIDTH, 640: pixels per row, must be ≥ 3.
- IMG_HEIGHT, 480: rows per frame, must be ≥ 3.
- XW, $clog2(IMG_WIDTH): column counter width.
- YW, $clog2(IMG_HEIGHT): row counter width.

Ports:
- clk  in  1  system clock. One clock only; all logic on the rising edge.
- rst_n  in  1  system reset. Synchronous and active-high (resets when 1).
- in_valid  in  1  in_pixel is accepted on this edge.
- in_sof  in  1  start of frame; qualified by in_valid; marks pixel (0,0).
- in_pixel  in  8  input pixel.
- out_valid  out  1  win, out_x and out_y are valid this cycle.
- win  out  72  3x3 window; element (r,c) at bits [8*(3r+c)+7 : 8*(3r+c)]; r=0 is the top (oldest) row; c=0 is the leftmost column.
- out_x  out  XW  column of the window centre.
- out_y  out  YW  row of the window centre.
- frame_done  out  1  one-cycle pulse: last pixel (IMG_HEIGHT-1, IMG_WIDTH-1) accepted.
- sync_err  out  1  one-cycle pulse: in_sof arrived while the frame was incomplete.

## Operation
- Counters x (column) and y (row) give the position of the next accepted pixel.
  - Advance only when in_valid=1.
  - x wraps at IMG_WIDTH-1 and increments y.
  - y wraps at IMG_HEIGHT-1 back to 0.
  - The pixel after (H-1, W-1) is (0,0) whether or not in_sof is set.
- in_sof with in_valid: the pixel is taken as (0,0); counters then move to (0,1).
  - sync_err pulses if in_sof arrives while (x,y) ≠ (0,0).
  - No window is emitted until the new frame reaches (2,2).
- Line RAMs:
  - L1 holds row y-1 and L2 holds row y-2. Each is IMG_WIDTH x 8.
  - On accept at column x: L2[x] ← L1[x] and L1[x] ← in_pixel. Read before write, so the same address is used in the same cycle.
  - RAM contents are not reset; stale data is never exposed.
- Window shift register:
  - 3 rows x 3 columns. Columns shift left on each accept.
  - The new right column is {L2[x], L1[x], in_pixel}.
  - It is cleared at x=0, i.e. the window never spans a row boundary.
- Emit rule: an accept at (x,y) with x ≥ 2 and y ≥ 2 produces a window covering rows y-2..y and cols x-2..x.
  - Centre is (x-1, y-1); out_x=x-1, out_y=y-1.
  - win[71:64] = pixel (y,x); win[7:0] = pixel (y-2,x-2).
- Windows per frame: exactly (IMG_HEIGHT-2)*(IMG_WIDTH-2). No border replication; border centres are never emitted.
- No backpressure. The downstream must accept every out_valid cycle.

## Timing
- Latency: accept on edge N gives out_valid=1 for the cycle after edge N, together with win, out_x and out_y.
- Outputs are registered. out_valid is high for exactly one cycle per qualifying accept, and low on cycles with no accept.
- win, out_x and out_y hold their last value while out_valid=0.
- frame_done and sync_err are registered and aligned with the out_valid of the same accept.
- Continuous in_valid gives back-to-back out_valid within a row and gaps of 2 cycles at each row start (x=0,1).
- Reset: when rst_n=1 at an edge, the following outputs are 0 from the next cycle:
  - out_valid, win, out_x, out_y, frame_done, sync_err.
  - Counters (0,0) and the window register 0.
  - Reset overrides a simultaneous in_valid; that pixel is dropped.
- The first pixel after reset is (0,0) whether or not in_sof is set.
- Reset mid-frame: no window is emitted until the new frame's (2,2).
- Simultaneous in_sof and frame-complete ((x,y)=(0,0)): normal start, no sync_err.

## Test plan
- Ramp: W=5, H=4, pixel=10y+x, continuous in_valid.
  - Exactly 6 windows, centres (1,1),(2,1),(3,1),(1,2),(2,2),(3,2).
  - First window: win bytes = 0,1,2,10,11,12,20,21,22, one cycle after pixel 22 is accepted.
  - frame_done pulses with the window of pixel 34.
- Gapped input: same frame with in_valid toggled pseudo-randomly at 50%.
  - Identical window sequence and values.
  - out_valid only in cycles following accepts.
- Mid-frame sof: in_sof at pixel position (1,2) of frame 1.
  - sync_err pulses once.
  - No windows until the new frame accepts (2,2); its first window holds only new-frame values.
- Reset mid-frame: rst_n=1 for one cycle during row 2.
  - All outputs are 0 the next cycle.
  - The next pixel is treated as (0,0).
  - The full 6-window ramp result is reproduced.
- Back-to-back frames: two frames of W=5, H=4 with no idle cycle; frame 2 = 100+10y+x.
  - 12 windows total; no sync_err.
  - The first frame-2 window is 100,101,102,110,111,112,120,121,122.
- Row-boundary check: W=3, H=3.
  - Exactly one window, centre (1,1).
  - Row-start windows never mix columns from adjacent rows.
